// File: rtl/k051962_pkg.sv
// k051962_pkg: shared types and helpers for the k051962 plane shifter.
//   pix_entry_t  - one window entry: 4-bit colour index plus palette field.
//   TILE_W       - pixels per tile row.
//   WIN_DEPTH    - entries in the fine-scroll pixel window.
//   PLANEn_LSB   - bit offset of bitplane n inside the 32-bit ROM word.
package k051962_pkg;

  localparam int TILE_W     = 8;
  localparam int WIN_DEPTH  = 16;
  localparam int PIX_W      = 4;
  // Palette field is sized for the widest slice of COL; only the top PAL_W
  // bits are ever non-zero.
  localparam int PAL_MAX_W  = 8;

  localparam int PLANE0_LSB = 0;
  localparam int PLANE1_LSB = 8;
  localparam int PLANE2_LSB = 16;
  localparam int PLANE3_LSB = 24;

  typedef struct packed {
    logic [PIX_W-1:0]     pix;
    logic [PAL_MAX_W-1:0] pal;
  } pix_entry_t;

  // Gather pixel k (0 = leftmost) across the four planes, plane 3 as MSB.
  function automatic logic [PIX_W-1:0] plane_pixel(input logic [31:0] romd, input int k);
    plane_pixel = {romd[PLANE3_LSB + TILE_W - 1 - k],
                   romd[PLANE2_LSB + TILE_W - 1 - k],
                   romd[PLANE1_LSB + TILE_W - 1 - k],
                   romd[PLANE0_LSB + TILE_W - 1 - k]};
  endfunction

  // Keep COL[7:8-pal_w] in place and clear the lower bits.
  function automatic logic [PAL_MAX_W-1:0] pal_field(input logic [7:0] col, input int pal_w);
    pal_field = col & ~(8'hFF >> pal_w);
  endfunction

endpackage

// File: rtl/k051962_row_decode.sv
// k051962_row_decode: combinational decode of one tile row.
//   romd     in  32  four bitplanes of eight pixels
//   col      in  8   tile attribute byte
//   flipx_en in  1   global enable for per-tile X flip (COL[FLIP_BIT])
//   row      out     eight window entries, row[0] is the leftmost pixel
module k051962_row_decode
  import k051962_pkg::*;
#(
  parameter int PAL_W    = 4,
  parameter int FLIP_BIT = 0
) (
  input  logic                    [31:0] romd,
  input  logic                    [7:0]  col,
  input  logic                           flipx_en,
  output pix_entry_t [TILE_W-1:0]        row
);

  logic flip;

  assign flip = flipx_en & col[FLIP_BIT];

  // Build the eight entries, mirroring pixel order when flip is requested.
  always_comb begin
    row = '0;
    for (int k = 0; k < TILE_W; k++) begin
      if (flip) begin
        row[k].pix = plane_pixel(romd, TILE_W - 1 - k);
      end else begin
        row[k].pix = plane_pixel(romd, k);
      end
      row[k].pal = pal_field(col, PAL_W);
    end
  end

endmodule

// File: rtl/k051962_plane_shifter.sv
// k051962_plane_shifter: serialises tile rows into a per-pixel colour stream
// with fine horizontal scroll through a 16-entry window.
//   M24      in  1      master clock
//   RES      in  1      asynchronous active-high reset
//   CE       in  1      pixel enable, qualifies every action
//   LOAD     in  1      tile-row load strobe (ignored when CE=0)
//   ROMD     in  32     four bitplanes, plane p in [8p+7:8p]
//   COL      in  8      tile attribute byte
//   FINE     in  3      fine scroll, selects the window tap
//   FLIPX_EN in  1      enables per-tile X flip
//   BLANK    in  1      forces a transparent output
//   PIX      out 4      registered colour index
//   PAL      out PAL_W  registered palette bits
//   OPAQUE   out 1      PIX non-zero and not blanked
//   LATE     out 1      one-CE pulse on a load cadence error
module k051962_plane_shifter
  import k051962_pkg::*;
#(
  parameter int PAL_W    = 4,
  parameter int FLIP_BIT = 0
) (
  input  logic             M24,
  input  logic             RES,
  input  logic             CE,
  input  logic             LOAD,
  input  logic [31:0]      ROMD,
  input  logic [7:0]       COL,
  input  logic [2:0]       FINE,
  input  logic             FLIPX_EN,
  input  logic             BLANK,
  output logic [3:0]       PIX,
  output logic [PAL_W-1:0] PAL,
  output logic             OPAQUE,
  output logic             LATE
);

  pix_entry_t                win [WIN_DEPTH];
  pix_entry_t [TILE_W-1:0]   tile_row;
  logic       [2:0]          ph;
  logic                      seen_load;

  k051962_row_decode #(
    .PAL_W    (PAL_W),
    .FLIP_BIT (FLIP_BIT)
  ) u_row_decode (
    .romd     (ROMD),
    .col      (COL),
    .flipx_en (FLIPX_EN),
    .row      (tile_row)
  );

  // Pixel window: shift toward entry 0 each CE; a load overrides the upper half.
  always_ff @(posedge M24 or posedge RES) begin
    if (RES) begin
      for (int i = 0; i < WIN_DEPTH; i++) begin
        win[i] <= '0;
      end
    end else if (CE) begin
      for (int i = 0; i < WIN_DEPTH - 1; i++) begin
        win[i] <= win[i+1];
      end
      win[WIN_DEPTH-1] <= '0;
      if (LOAD) begin
        for (int k = 0; k < TILE_W; k++) begin
          win[TILE_W+k] <= tile_row[k];
        end
      end
    end
  end

  // Phase counter and cadence monitor; the very first load after reset
  // cannot be early because there is no previous tile to measure against.
  always_ff @(posedge M24 or posedge RES) begin
    if (RES) begin
      ph        <= 3'd0;
      seen_load <= 1'b0;
      LATE      <= 1'b0;
    end else if (CE) begin
      if (LOAD) begin
        ph        <= 3'd0;
        seen_load <= 1'b1;
        LATE      <= seen_load & (ph != 3'd7);
      end else begin
        ph        <= ph + 3'd1;
        LATE      <= (ph == 3'd7);
      end
    end
  end

  // Output register: tap the window at FINE before this edge's shift.
  always_ff @(posedge M24 or posedge RES) begin
    if (RES) begin
      PIX    <= 4'd0;
      PAL    <= '0;
      OPAQUE <= 1'b0;
    end else if (CE) begin
      if (BLANK) begin
        PIX    <= 4'd0;
        PAL    <= '0;
        OPAQUE <= 1'b0;
      end else begin
        PIX    <= win[{1'b0, FINE}].pix;
        PAL    <= win[{1'b0, FINE}].pal[PAL_MAX_W-1 -: PAL_W];
        OPAQUE <= (win[{1'b0, FINE}].pix != 4'd0);
      end
    end
  end

endmodule

// File: tb/tb_k051962_plane_shifter.sv
module tb_k051962_plane_shifter;

  logic        m24;
  logic        res;
  logic        ce;
  logic        load;
  logic [31:0] romd;
  logic [7:0]  col;
  logic [2:0]  fine;
  logic        flipx_en;
  logic        blank;
  logic [3:0]  pix;
  logic [3:0]  pal;
  logic        opaque;
  logic        late;

  k051962_plane_shifter #(.PAL_W(4), .FLIP_BIT(0)) dut (
    .M24      (m24),
    .RES      (res),
    .CE       (ce),
    .LOAD     (load),
    .ROMD     (romd),
    .COL      (col),
    .FINE     (fine),
    .FLIPX_EN (flipx_en),
    .BLANK    (blank),
    .PIX      (pix),
    .PAL      (pal),
    .OPAQUE   (opaque),
    .LATE     (late)
  );

  initial m24 = 1'b0;
  always #5 m24 = ~m24;

  int n_checks = 0;
  int n_fail   = 0;

  // ROM words: ROM_A gives pixel k = k, ROM_B gives pixel k = k + 8.
  localparam logic [31:0] ROM_A    = 32'h000F_3355;
  localparam logic [31:0] ROM_B    = 32'hFF0F_3355;
  localparam logic [31:0] TBL_ROMD = 32'hFF00_F00F;

  // ---------------- reference model ----------------
  // A tile loaded at CE edge L places pixel k at window slot 8+k; after each
  // later CE it sits one slot lower. The newest load covering a slot wins.
  typedef struct {
    int          ld_edge;
    logic [31:0] pixs;
    logic [3:0]  pal;
  } ld_t;

  ld_t        ldq[$];
  int         m_n;
  int         m_last;
  bit         m_seen;
  logic [3:0] m_pix;
  logic [3:0] m_pal;
  logic       m_opq;
  logic       m_late;

  function automatic logic [7:0] model_slot(input int f, input int d);
    for (int i = ldq.size() - 1; i >= 0; i--) begin
      int k;
      k = f - 8 + (d - ldq[i].ld_edge);
      if (k > 7) return 8'h00;
      if (k >= 0) return {ldq[i].pixs[4*k +: 4], ldq[i].pal};
    end
    return 8'h00;
  endfunction

  task automatic model_reset();
    ldq.delete();
    m_n = 0; m_last = 0; m_seen = 1'b0;
    m_pix = 4'd0; m_pal = 4'd0; m_opq = 1'b0; m_late = 1'b0;
  endtask

  task automatic model_edge(input logic l, input logic [31:0] rd, input logic [7:0] cl,
                            input logic [2:0] f, input logic fx, input logic b);
    logic [7:0]  e;
    logic [31:0] p;
    int          phb;
    int          src;
    m_n = m_n + 1;
    e = model_slot(int'(f), m_n - 1);
    if (b) begin
      m_pix = 4'd0; m_pal = 4'd0; m_opq = 1'b0;
    end else begin
      m_pix = e[7:4]; m_pal = e[3:0]; m_opq = (e[7:4] != 4'd0);
    end
    phb = (m_n - 1 - m_last) % 8;
    if (l) begin
      m_late = m_seen && (phb != 7);
      m_seen = 1'b1;
      m_last = m_n;
      for (int k = 0; k < 8; k++) begin
        src = (fx && cl[0]) ? 7 - k : k;
        p[4*k +: 4] = {rd[31-src], rd[23-src], rd[15-src], rd[7-src]};
      end
      ldq.push_back('{ld_edge: m_n, pixs: p, pal: cl[7:4]});
      while (ldq.size() > 0 && ldq[0].ld_edge < m_n - 24) void'(ldq.pop_front());
    end else begin
      m_late = (phb == 7);
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_pix"}, pix, m_pix);
    chk({tag, "_pal"}, pal, m_pal);
    chk({tag, "_opaque"}, opaque, m_opq);
    chk({tag, "_late"}, late, m_late);
  endtask

  task automatic step(input logic c, input logic l, input logic [31:0] rd, input logic [7:0] cl,
                      input logic [2:0] f, input logic fx, input logic b, input bit use_model,
                      input string tag);
    ce = c; load = l; romd = rd; col = cl; fine = f; flipx_en = fx; blank = b;
    @(posedge m24);
    #1;
    if (c) model_edge(l, rd, cl, f, fx, b);
    if (use_model) chk_model(tag);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic do_reset(input string tag);
    ce = 1'b0; load = 1'b0; blank = 1'b0;
    #3;
    res = 1'b1;
    #1;
    model_reset();
    chk_model(tag);
    repeat (2) @(negedge m24);
    res = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       load;
    logic [7:0] col;
    logic       flipx;
    logic [3:0] exp_pix;
    logic [3:0] exp_pal;
    logic       exp_opq;
    logic       exp_late;
  } vec_t;

  vec_t       tbl [49];
  logic [7:0] tcol  [7];
  logic       tfx   [7];
  logic       tflip [7];
  logic [3:0] seq_plain [8];
  logic [3:0] seq_flip  [8];

  task automatic fill_table();
    int t;
    int k;
    seq_plain = '{4'hA, 4'hA, 4'hA, 4'hA, 4'h9, 4'h9, 4'h9, 4'h9};
    seq_flip  = '{4'h9, 4'h9, 4'h9, 4'h9, 4'hA, 4'hA, 4'hA, 4'hA};
    tcol  = '{8'hA0, 8'hA0, 8'hA1, 8'hA1, 8'hA1, 8'hA0, 8'hA0};
    tfx   = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0};
    tflip = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0};
    for (int e = 1; e <= 49; e++) begin
      t = (e - 1) / 8;
      tbl[e-1].load     = ((e - 1) % 8 == 0);
      tbl[e-1].col      = tcol[t];
      tbl[e-1].flipx    = tfx[t];
      tbl[e-1].exp_late = 1'b0;
      if (e < 10) begin
        tbl[e-1].exp_pix = 4'h0; tbl[e-1].exp_pal = 4'h0; tbl[e-1].exp_opq = 1'b0;
      end else begin
        t = (e - 10) / 8;
        k = (e - 10) % 8;
        tbl[e-1].exp_pix = tflip[t] ? seq_flip[k] : seq_plain[k];
        tbl[e-1].exp_pal = 4'hA;
        tbl[e-1].exp_opq = 1'b1;
      end
    end
  endtask

  logic [2:0] rf;

  initial begin
    res = 1'b0; ce = 1'b0; load = 1'b0; romd = 32'h0; col = 8'h0;
    fine = 3'd0; flipx_en = 1'b0; blank = 1'b0;
    fill_table();

    do_reset("reset");

    // Table: FINE=0, loads every 8 CE, plain / flipped / flip-disabled tiles.
    for (int i = 0; i < 49; i++) begin
      step(1'b1, tbl[i].load, TBL_ROMD, tbl[i].col, 3'd0, tbl[i].flipx, 1'b0, 1'b0, "tbl");
      chk("tbl_pix", pix, tbl[i].exp_pix);
      chk("tbl_pal", pal, tbl[i].exp_pal);
      chk("tbl_opaque", opaque, tbl[i].exp_opq);
      chk("tbl_late", late, tbl[i].exp_late);
    end

    // Reset mid-tile, then 16 CE with no load stay transparent.
    do_reset("midreset");
    for (int e = 1; e <= 16; e++) begin
      step(1'b1, 1'b0, ROM_B, 8'hF0, 3'd0, 1'b0, 1'b0, 1'b1, "drain");
      chk("post_reset_pix", pix, 8'h00);
      chk("post_reset_opaque", opaque, 8'h00);
    end

    // Fine scroll 3 across tiles A then B, switching to FINE=0 at edge 16.
    do_reset("reset_fine");
    for (int e = 1; e <= 20; e++) begin
      step(1'b1, ((e - 1) % 8 == 0), (((e - 1) / 8) % 2 == 0) ? ROM_A : ROM_B, 8'h50,
           (e <= 15) ? 3'd3 : 3'd0, 1'b0, 1'b0, 1'b1, "fine");
      if (e == 10) chk("fine3_first_pix", pix, 8'd3);
      if (e == 15) chk("fine3_b_pixel0", pix, 8'd8);
      if (e == 16) chk("fine0_switch", pix, 8'd6);
    end

    // Cadence: early load at ph=5, then a missed load, then drain.
    do_reset("reset_cad");
    for (int e = 1; e <= 42; e++) begin
      step(1'b1, (e == 1 || e == 9 || e == 15 || e == 23), ROM_B, 8'h30, 3'd0, 1'b0, 1'b0,
           1'b1, "cad");
      if (e == 15) chk("late_early", late, 8'd1);
      if (e == 16) chk("late_early_clear", late, 8'd0);
      if (e == 23) chk("late_ontime", late, 8'd0);
      if (e == 31) chk("late_missed", late, 8'd1);
      if (e == 32) chk("late_missed_clear", late, 8'd0);
      if (e == 38) chk("pre_drain_pix", pix, 8'hE);
      if (e == 41) chk("drained_opaque", opaque, 8'd0);
    end

    // BLANK for three CE, then CE held low with a stray LOAD.
    do_reset("reset_blank");
    for (int e = 1; e <= 17; e++) begin
      step(1'b1, ((e - 1) % 8 == 0), ROM_A, 8'h70, 3'd0, 1'b0, (e >= 12 && e <= 14), 1'b1,
           "blank");
      if (e == 13) chk("blank_pix", pix, 8'd0);
      if (e == 13) chk("blank_opaque", opaque, 8'd0);
      if (e == 15) begin
        chk("after_blank_pix", pix, 8'd5);
        for (int h = 0; h < 5; h++) begin
          step(1'b0, 1'b1, ROM_B, 8'hF1, 3'd4, 1'b1, 1'b0, 1'b1, "hold");
          chk("hold_pix", pix, 8'd5);
        end
      end
      if (e == 16) chk("resume_pix", pix, 8'd6);
      if (e == 17) chk("resume_late", late, 8'd0);
    end

    // Randomised run against the model.
    do_reset("reset_rand");
    rf = 3'd0;
    for (int it = 0; it < 3000; it++) begin
      logic c;
      logic l;
      int   phb;
      c = ($urandom_range(0, 3) != 0);
      phb = (m_n - m_last) % 8;
      if (!c) l = $urandom_range(0, 1);
      else if (phb == 7) l = ($urandom_range(0, 19) != 0);
      else l = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) == 0) rf = 3'($urandom_range(0, 7));
      step(c, l, $urandom, 8'($urandom), rf, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 11) == 0), 1'b1, "rand");
      if ($urandom_range(0, 599) == 0) do_reset("rand_reset");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
